// File: rtl/bootrom_read_port.sv
// Read-port master for the synchronous mask-ROM macro.
// Takes byte-addressed burst requests, issues one word read per credit into
// the ROM, and returns the words through a small first-word-fall-through
// buffer. Misaligned requests return a single error beat without touching
// the ROM.
`timescale 1ns/1ps
module bootrom_read_port #(
  parameter int ADDR_BITS  = 11,
  parameter int DATA_BITS  = 32,
  parameter int LEN_BITS   = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_BITS+1:0] req_addr,
  input  logic [LEN_BITS-1:0]  req_len,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [DATA_BITS-1:0] resp_data,
  output logic                 resp_last,
  output logic                 resp_err,
  output logic                 rom_me,
  output logic                 rom_oe,
  output logic [ADDR_BITS-1:0] rom_address,
  input  logic [DATA_BITS-1:0] rom_q
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // Wide enough to hold FIFO_DEPTH + 1 (full buffer plus one word in flight).
  localparam int CNT_W = $clog2(FIFO_DEPTH + 2);
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [LEN_BITS:0] ONE_BEAT = (LEN_BITS + 1)'(1);

  typedef enum logic [1:0] {IDLE, BURST, ERR} state_t;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 last;
    logic                 err;
  } entry_t;

  state_t               state;
  logic [ADDR_BITS-1:0] word_addr;
  logic [LEN_BITS:0]    beats_left;
  logic                 inflight;
  logic                 inflight_last;

  entry_t               mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [CNT_W-1:0]     fifo_count;

  logic                 empty;
  logic                 pop;
  logic                 push;
  logic                 has_space;
  logic                 issue;
  logic                 issue_last;
  logic                 err_push;
  logic [CNT_W-1:0]     used;
  logic [CNT_W-1:0]     avail;
  entry_t               push_entry;
  entry_t               head;

  // Credit check: a slot must be free for every word already committed
  // (buffered or in flight), counting the slot the consumer frees this cycle.
  assign empty      = (fifo_count == '0);
  assign pop        = !empty && resp_ready;
  assign used       = fifo_count + CNT_W'(inflight);
  assign avail      = DEPTH_C + CNT_W'(pop);
  assign has_space  = (used < avail);
  assign issue      = (state == BURST) && has_space;
  assign issue_last = (beats_left == ONE_BEAT);
  assign err_push   = (state == ERR) && has_space;
  assign push       = inflight || err_push;
  assign head       = mem[rd_ptr];

  // Select what enters the buffer: the returning ROM word or an error marker.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    push_entry = '{data: '0, last: 1'b1, err: 1'b1};
    if (inflight) begin
      push_entry = '{data: rom_q, last: inflight_last, err: 1'b0};
    end
  end

  // Request FSM: accept, walk the burst one credit-gated issue at a time.
  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      word_addr  <= '0;
      beats_left <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_addr[1:0] != 2'b00) begin
              state <= ERR;
            end else begin
              word_addr  <= req_addr[ADDR_BITS+1:2];
              beats_left <= {1'b0, req_len} + ONE_BEAT;
              state      <= BURST;
            end
          end
        end
        BURST: begin
          if (has_space) begin
            word_addr  <= word_addr + 1'b1;
            beats_left <= beats_left - ONE_BEAT;
            if (issue_last) state <= IDLE;
          end
        end
        ERR: begin
          if (has_space) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One-deep read pipeline: a word issued this cycle is captured next cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && issue_last;
    end
  end

  // Buffer pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (!push && pop) fifo_count <= fifo_count - 1'b1;
    end
  end

  // Buffer storage write.
  // NOTE: storage is deliberately not reset; occupancy is tracked by the
  // pointers and count, so stale entries are never presented as valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // Outputs are forced to their idle values for the whole reset cycle.
  assign req_ready   = !reset && (state == IDLE);
  assign rom_me      = !reset && issue;
  assign rom_oe      = !reset;
  assign rom_address = reset ? '0 : word_addr;
  assign resp_valid  = !reset && !empty;
  assign resp_data   = reset ? '0 : head.data;
  assign resp_last   = !reset && !empty && head.last;
  assign resp_err    = !reset && !empty && head.err;

endmodule

// File: tb/tb_bootrom_read_port.sv
// Bench for bootrom_read_port: behavioural ROM, scoreboard queues for ROM
// addresses and response beats, a vector table plus hand-timed sequences.
`timescale 1ns/1ps
module tb_bootrom_read_port;

  localparam int ADDR_BITS  = 11;
  localparam int DATA_BITS  = 32;
  localparam int LEN_BITS   = 4;
  localparam int FIFO_DEPTH = 2;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        err;
  } beat_t;

  typedef struct {
    logic [12:0] addr;
    logic [3:0]  len;
    int          stall;
    logic        exp_err;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [12:0] req_addr;
  logic [3:0]  req_len;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_last;
  logic        resp_err;
  logic        rom_me;
  logic        rom_oe;
  logic [10:0] rom_address;
  logic [31:0] rom_q = 32'h0;

  beat_t       exp_q[$];
  logic [10:0] addr_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          rom_me_count = 0;
  int          beat_count = 0;
  bit          overflow_seen = 1'b0;
  bit          prev_stall = 1'b0;
  beat_t       prev_beat;

  bootrom_read_port #(
    .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS),
    .LEN_BITS(LEN_BITS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_last(resp_last), .resp_err(resp_err),
    .rom_me(rom_me), .rom_oe(rom_oe), .rom_address(rom_address),
    .rom_q(rom_q)
  );

  always #5 clock = ~clock;

  // ROM contents: distinct, non-zero word per address.
  function automatic logic [31:0] rom_word(input logic [10:0] a);
    return {a, 21'h0} ^ {21'h0, a} ^ 32'hC3A5_5A3C;
  endfunction

  // Behavioural mask ROM: output register loads only on rom_me.
  always @(posedge clock) begin
    if (rom_me) rom_q <= rom_word(rom_address);
  end

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
  endtask

  // Monitor: ROM issue addresses, response beats, hold-under-stall.
  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (rom_me) begin
        rom_me_count++;
        if (addr_q.size() == 0) check("rom_me_unexpected", rom_me, 0);
        else check("rom_address", rom_address, addr_q.pop_front());
      end
      if (prev_stall)
        check("resp_hold", {resp_valid, resp_data, resp_last, resp_err}, {1'b1, prev_beat});
      if (resp_valid && resp_ready) begin
        beat_count++;
        if (exp_q.size() == 0) check("beat_unexpected", resp_valid, 0);
        else check("resp_beat", {resp_data, resp_last, resp_err}, exp_q.pop_front());
      end
      prev_stall = resp_valid && !resp_ready;
      prev_beat  = {resp_data, resp_last, resp_err};
    end
  end

  // Buffer overflow watch: a push into a full buffer with no pop.
  always @(negedge clock) begin
    if (!reset && dut.push && !dut.pop && (int'(dut.fifo_count) == FIFO_DEPTH))
      overflow_seen = 1'b1;
  end

  task automatic expect_req(input logic [12:0] a, input logic [3:0] l);
    logic [10:0] wa;
    beat_t       b;
    if (a[1:0] != 2'b00) begin
      b = {32'h0, 1'b1, 1'b1};
      exp_q.push_back(b);
    end else begin
      for (int i = 0; i <= int'(l); i++) begin
        wa = a[12:2] + 11'(i);
        addr_q.push_back(wa);
        b = {rom_word(wa), (i == int'(l)), 1'b0};
        exp_q.push_back(b);
      end
    end
  endtask

  // Drive a request, wait (bounded) for acceptance; returns just after the
  // handshake edge.
  task automatic send_req(input logic [12:0] a, input logic [3:0] l);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (req_ready) break;
    end
    check("req_accept", req_ready, 1);
    expect_req(a, l);
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      #1;
      if (exp_q.size() == 0 && addr_q.size() == 0) break;
    end
    check("drain", exp_q.size() + addr_q.size(), 0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    int   b0, c0, n, exp_n;

    vecs[0] = '{addr: 13'h0100, len: 4'd3,  stall: 0, exp_err: 1'b0};
    vecs[1] = '{addr: 13'h0100, len: 4'd3,  stall: 5, exp_err: 1'b0};
    vecs[2] = '{addr: 13'h1FFC, len: 4'd1,  stall: 0, exp_err: 1'b0};
    vecs[3] = '{addr: 13'h07F0, len: 4'd15, stall: 3, exp_err: 1'b0};
    vecs[4] = '{addr: 13'h0003, len: 4'd0,  stall: 0, exp_err: 1'b1};
    vecs[5] = '{addr: 13'h0004, len: 4'd7,  stall: 0, exp_err: 1'b0};
    vecs[6] = '{addr: 13'h1FF8, len: 4'd4,  stall: 2, exp_err: 1'b0};

    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; resp_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_outputs", {req_ready, resp_valid, resp_last, resp_err, resp_data,
                            rom_me, rom_oe, rom_address}, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rom_oe_after_reset", rom_oe, 1);
    check("req_ready_idle", req_ready, 1);
    @(posedge clock);
    #1;

    // Aligned single read with exact latency.
    send_req(13'h0010, 4'd0);
    @(negedge clock);
    check("single_issue", {rom_me, rom_address}, {1'b1, 11'd4});
    @(negedge clock);
    check("single_not_yet", resp_valid, 0);
    @(negedge clock);
    check("single_beat", {resp_valid, resp_data, resp_last, resp_err},
          {1'b1, rom_word(11'd4), 1'b1, 1'b0});
    @(posedge clock);
    #1;
    wait_drain(20);

    // Misaligned request: error beat, no ROM access, back to idle.
    b0 = rom_me_count;
    send_req(13'h0006, 4'd2);
    @(negedge clock);
    check("err_busy", req_ready, 0);
    @(negedge clock);
    check("err_beat", {req_ready, resp_valid, resp_data, resp_last, resp_err},
          {1'b1, 1'b1, 32'h0, 1'b1, 1'b1});
    @(posedge clock);
    #1;
    wait_drain(20);
    check("err_no_rom", rom_me_count - b0, 0);

    // Vector table.
    foreach (vecs[k]) begin
      b0 = rom_me_count;
      c0 = beat_count;
      exp_n = vecs[k].exp_err ? 1 : int'(vecs[k].len) + 1;
      if (vecs[k].stall > 0) resp_ready = 1'b0;
      send_req(vecs[k].addr, vecs[k].len);
      if (vecs[k].stall > 0) begin
        repeat (vecs[k].stall) @(posedge clock);
        #1;
        check("bp_issue_limit", (rom_me_count - b0) <= 2, 1);
        resp_ready = 1'b1;
      end else if (!vecs[k].exp_err) begin
        n = 0;
        while ((beat_count - c0) < exp_n && n < 100) begin
          @(negedge clock);
          #1;
          n++;
        end
        check("stream_cycles", n, exp_n + 2);
      end
      wait_drain(200);
      check("vec_issues", rom_me_count - b0, vecs[k].exp_err ? 0 : exp_n);
      check("vec_beats", beat_count - c0, exp_n);
    end

    // Reset in the middle of a 16-beat burst, at the 3rd beat.
    b0 = rom_me_count;
    c0 = beat_count;
    send_req(13'h0000, 4'd15);
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      #1;
      if ((beat_count - c0) >= 2) break;
    end
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("midburst_reset_outputs", {req_ready, resp_valid, resp_last, resp_err, resp_data,
                                     rom_me, rom_oe, rom_address}, 0);
    exp_q.delete();
    addr_q.delete();
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    check("reset_beats", beat_count - c0, 2);
    check("reset_issues", rom_me_count - b0, 4);
    c0 = beat_count;
    send_req(13'h0040, 4'd0);
    wait_drain(20);
    check("post_reset_beats", beat_count - c0, 1);

    check("fifo_no_overflow", overflow_seen, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bootrom_read_port.md
Name: bootrom_read_port

Overview:
- Initiator-side master for the synchronous mask-ROM macro port (`me`/`oe`/`address`/`q`).
- Accepts byte-addressed burst read requests over a valid/ready channel and sequences word reads into the ROM.
- Returns the data on a backpressurable response stream.
- Sits between the boot fetch path and the BootROM instance, so the ROM is only ever driven by this block.

Parameters:
- ADDR_BITS, 11, ROM word-address width; ROM depth is 2^ADDR_BITS words.
- DATA_BITS, 32, ROM word width.
- LEN_BITS, 4, burst length field width; a burst carries up to 2^LEN_BITS beats.
- FIFO_DEPTH, 2, response buffer entries; must be >= 2.

Ports:
- clock  in  1  sole clock; every flop is on its rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_addr  in  ADDR_BITS+2  byte address of the first word.
- req_len  in  LEN_BITS  beat count minus 1.
- resp_valid  out  1  response beat available.
- resp_ready  in  1  consumer accepts the beat.
- resp_data  out  DATA_BITS  read word.
- resp_last  out  1  final beat of the burst.
- resp_err  out  1  request was misaligned.
- rom_me  out  1  ROM memory enable; ROM registers q on this edge.
- rom_oe  out  1  ROM output enable.
- rom_address  out  ADDR_BITS  ROM word address.
- rom_q  in  DATA_BITS  ROM read data, valid the cycle after rom_me.

Behaviour:
- Reset is synchronous, active-high, on clock.
  - While reset is high: req_ready=0, resp_valid=0, resp_last=0, resp_err=0, resp_data=0, rom_me=0, rom_oe=0, rom_address=0.
  - Reset clears the FSM, counters and FIFO.
- rom_oe is 1 in every cycle after reset deasserts.
- FSM states: IDLE, BURST, ERR.
- IDLE:
  - req_ready=1.
  - On handshake with req_addr[1:0]!=0 -> ERR.
  - Otherwise latch word_addr=req_addr[ADDR_BITS+1:2] and beats_left=req_len+1 (LEN_BITS+1 bits), then -> BURST.
- ERR:
  - Pushes one entry into the FIFO with data=0, err=1, last=1. No ROM access.
  - -> IDLE once the push is done; the push waits for FIFO space.
- BURST:
  - req_ready=0.
  - Issue cycle: rom_me=1, rom_address=word_addr.
  - Issue condition is credit>0, where credit = FIFO_DEPTH - fifo_count - inflight + (resp_valid && resp_ready).
  - On issue: word_addr increments modulo 2^ADDR_BITS, so 2^ADDR_BITS-1 wraps to 0. beats_left decrements.
  - The issue with beats_left==1 is tagged last and moves the FSM -> IDLE.
  - A new request can be accepted in the cycle after the final issue.
- Read pipeline:
  - A word issued in cycle t is sampled from rom_q at the end of t+1 and pushed with err=0 and the last tag.
  - That word appears on resp_* from cycle t+2 at the earliest.
  - inflight is a 1-bit flag set on issue, consumed on the push.
- FIFO:
  - First-word-fall-through, FIFO_DEPTH entries of {data, last, err}.
  - resp_valid = !empty; outputs come from the head entry.
  - Simultaneous push and pop when full is legal, because the credit rule covers it.
  - Push when full is impossible by construction; a bench assertion checks it.
- resp_* are held stable while resp_valid && !resp_ready.
- Throughput: with resp_ready held at 1, a burst streams one beat per cycle.
- rom_me is 0 in every non-issue cycle, so the ROM output register holds its value.
- Reset mid-burst: abort immediately. Queued and in-flight beats are discarded, with no last beat emitted.
- req_len=0 gives a single beat with last=1.

Test Plan:
- Aligned single read:
  - Stimulus: req_addr=0x010, req_len=0, resp_ready=1.
  - Required: rom_me with rom_address=4 one cycle after the handshake; resp_valid exactly 2 cycles later with data=rom[4], last=1, err=0.
- Streaming burst:
  - Stimulus: req_addr=0x100, req_len=3, resp_ready=1.
  - Required: rom_address 64..67 on 4 consecutive rom_me cycles; 4 consecutive resp beats rom[64..67]; last only on the 4th.
- Backpressure:
  - Stimulus: same burst, resp_ready=0 for 5 cycles then 1.
  - Required: at most 2 rom_me issues before the stall; resp_data stable during the stall; all 4 beats delivered in order; no FIFO overflow assertion fires.
- Misaligned request:
  - Stimulus: req_addr=0x006, req_len=2.
  - Required: exactly one beat with err=1, last=1, data=0; rom_me never asserted; req_ready=1 again after the beat is pushed.
- Address wrap:
  - Stimulus: req_addr=0x1FFC, req_len=1.
  - Required: rom_address 2047 then 0; data rom[2047], then rom[0] with last=1.
- Reset mid-burst:
  - Stimulus: req_len=15 at 0x000; assert reset at the 3rd beat for 1 cycle.
  - Required: all outputs return to their reset values that cycle; no further beats; a following request at 0x040 returns rom[16] normally.
